bcd_sevenseg_scan: RTL and testbench
====================================

// Module: bcd_sevenseg_scan
// PURPOSE
//  Downstream display stage for the 3-digit BCD counter. Takes units/tens/hundreds
//  and time-multiplexes them onto one shared 7-segment bus plus 3 digit enables.
//  Inputs are snapshotted once per scan frame, so a digit never tears mid-frame.
//  Feeds board anode/segment pins directly.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles per digit slot (>=1; 1 = advance every cycle)
//  ACTIVE_LOW   1       1: seg/an driven active-low (common-anode); 0: active-high
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  rst         in   1  synchronous, active-high reset
//  units       in   4  BCD digit 0 (from counter)
//  tens        in   4  BCD digit 1
//  hundreds    in   4  BCD digit 2
//  seg         out  7  segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
//  an          out  3  digit enables {hundreds,tens,units}, one-hot when active
//  frame_done  out  1  1-cycle pulse: snapshot captured, new frame starts
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): prescaler=0, state=S_U, snapshots=0,
//   an=all off, seg=all off, frame_done=0. Off = 1 if ACTIVE_LOW, else 0.
//   Applies mid-frame too: everything back to reset values at that edge.
//  Prescaler: cnt counts 0..REFRESH_DIV-1, wraps to 0. tick = (cnt==REFRESH_DIV-1).
//  FSM (advances only on tick): S_U -> S_T -> S_H -> S_U.
//   Tick in S_H also loads the snapshot regs from units/tens/hundreds.
//   frame_done=1 on the cycle after that tick, else 0.
//  Output regs: registered from current state + snapshot, so 1 cycle latency
//   behind the state reg. S_U -> an[0], S_T -> an[1], S_H -> an[2].
//  Decode (active-high view, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//   8=7F 9=6F. Non-BCD 10..15 -> 40 (dash, g only). ACTIVE_LOW inverts seg and an.
//  Snapshots reset to 0, so frame 1 after reset shows 000 whatever the inputs.
//   Live inputs first show in frame 2.
//  Input changes between captures are ignored. A change on the capture-tick edge
//   is taken (inputs sampled at that edge).
//  Digit sees REFRESH_DIV cycles of an; frame = 3*REFRESH_DIV cycles.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   hundreds slot blanked (an off, seg off) when snap_h==0.
//   tens slot blanked when snap_h==0 and snap_t==0.
//   units never blanked. Slot timing unchanged.
//   Non-BCD digit counts as nonzero, so it is never blanked.
//  Not defined: all three digits always shown, zeros included.
// TESTING (REFRESH_DIV=4, ACTIVE_LOW=1 unless stated)
//  1. rst=1 two cycles -> an=3'b111, seg=7'h7F, frame_done=0.
//     Release -> next cycle an=3'b110, seg=7'h40 ('0').
//  2. Hold h/t/u=1/2/3 from reset. Frame 1 (12 cycles) shows 0,0,0; frame_done
//     pulses once. Frame 2: an=110 seg=~4F, an=101 seg=~5B, an=011 seg=~06,
//     each 4 cycles.
//  3. Change units 3->7 mid-frame 2 -> stays 3 until frame_done; frame 3 units
//     seg=~07=7'h78.
//  4. units=4'hC -> that slot seg=7'h3F (dash). Assert rst during S_T ->
//     next cycle an=111, seg=7F, counter restarts at S_U.
//  5. With LEADING_ZERO_BLANK_EN, inputs 0/0/5: units shows ~6D; tens/hundreds
//     slots an=111 seg=7F. Inputs 0/4/0: tens ~66, units ~3F, hundreds blank.
//  6. REFRESH_DIV=1, ACTIVE_LOW=0 -> an steps 001,010,100 every cycle;
//     frame_done every 3rd cycle; seg uses the active-high codes.

Source files
------------

// File: rtl/bcd_sevenseg_scan.sv
// -----------------------------------------------------------------------------
// bcd_sevenseg_scan
//   Display stage for a 3-digit BCD counter. The three digits are
//   time-multiplexed onto one shared 7-segment bus with three digit enables.
//   All three inputs are snapshotted together once per scan frame, so a
//   displayed number never mixes digits from two different counter values.
//   seg/an are registered and can drive board pins directly.
//
// Parameters
//   REFRESH_DIV  clk cycles each digit stays enabled (>= 1)
//   ACTIVE_LOW   1: seg/an active-low (common anode), 0: active-high
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous active-high reset
//   units       in   4  BCD digit 0
//   tens        in   4  BCD digit 1
//   hundreds    in   4  BCD digit 2
//   seg         out  7  segments {g,f,e,d,c,b,a}
//   an          out  3  digit enables {hundreds,tens,units}
//   frame_done  out  1  one-cycle pulse, snapshot taken and a new frame starts
//
// Configuration macro
//   LEADING_ZERO_BLANK_EN  when defined, a zero hundreds digit is blanked and
//                          a zero tens digit is blanked if hundreds is also
//                          zero. Units is always shown. Slot timing unchanged.
// -----------------------------------------------------------------------------
module bcd_sevenseg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_done
);

  // A one-cycle slot still needs a 1-bit counter so the width never hits zero.
  localparam int               CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Pin levels that mean "nothing lit".
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_OFF  = ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {
    S_U = 2'd0,
    S_T = 2'd1,
    S_H = 2'd2
  } state_t;

  // BCD to segment pattern, active-high view {g,f,e,d,c,b,a}.
  // Codes 10..15 are not BCD and show a dash so a corrupted digit is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic             tick_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       snap_u_r;
  logic [3:0]       snap_t_r;
  logic [3:0]       snap_h_r;
  logic             capture_s;
  logic [3:0]       digit_s;
  logic [2:0]       onehot_s;
  logic             blank_s;
  logic             blank_t_s;
  logic             blank_h_s;
  logic [6:0]       seg_nxt_s;
  logic [2:0]       an_nxt_s;
  logic [6:0]       seg_r;
  logic [2:0]       an_r;
  logic             frame_done_r;

  assign tick_s    = (cnt_r == CNT_MAX);
  // The last tick of the hundreds slot closes the frame; that is the only
  // edge at which the live inputs are sampled.
  assign capture_s = tick_s && (state_r == S_H);

  // Slot prescaler: counts 0..REFRESH_DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (tick_s) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Scan state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_U;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: units -> tens -> hundreds, one step per slot tick.
  always_comb begin
    state_nxt_s = state_r;
    if (tick_s) begin
      case (state_r)
        S_U:     state_nxt_s = S_T;
        S_T:     state_nxt_s = S_H;
        S_H:     state_nxt_s = S_U;
        default: state_nxt_s = S_U;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Frame snapshot of the three input digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_u_r <= 4'd0;
      snap_t_r <= 4'd0;
      snap_h_r <= 4'd0;
    end else if (capture_s) begin
      snap_u_r <= units;
      snap_t_r <= tens;
      snap_h_r <= hundreds;
    end else begin
      snap_u_r <= snap_u_r;
      snap_t_r <= snap_t_r;
      snap_h_r <= snap_h_r;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Only a true zero blanks; a non-BCD code counts as nonzero.
  assign blank_h_s = (snap_h_r == 4'd0);
  assign blank_t_s = (snap_h_r == 4'd0) && (snap_t_r == 4'd0);
`else
  assign blank_h_s = 1'b0;
  assign blank_t_s = 1'b0;
`endif

  // Output decode: pick the slot's digit and enable, then apply polarity.
  always_comb begin
    digit_s   = 4'd0;
    onehot_s  = 3'b000;
    blank_s   = 1'b1;
    seg_nxt_s = SEG_OFF;
    an_nxt_s  = AN_OFF;
    case (state_r)
      S_U: begin
        digit_s  = snap_u_r;
        onehot_s = 3'b001;
        blank_s  = 1'b0;
      end
      S_T: begin
        digit_s  = snap_t_r;
        onehot_s = 3'b010;
        blank_s  = blank_t_s;
      end
      S_H: begin
        digit_s  = snap_h_r;
        onehot_s = 3'b100;
        blank_s  = blank_h_s;
      end
      default: begin
        digit_s  = 4'd0;
        onehot_s = 3'b000;
        blank_s  = 1'b1;
      end
    endcase
    if (blank_s) begin
      seg_nxt_s = SEG_OFF;
      an_nxt_s  = AN_OFF;
    end else if (ACTIVE_LOW) begin
      seg_nxt_s = ~bcd_to_seg(digit_s);
      an_nxt_s  = ~onehot_s;
    end else begin
      seg_nxt_s = bcd_to_seg(digit_s);
      an_nxt_s  = onehot_s;
    end
  end

  // Registered pin drivers; they lag the scan state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r        <= SEG_OFF;
      an_r         <= AN_OFF;
      frame_done_r <= 1'b0;
    end else begin
      seg_r        <= seg_nxt_s;
      an_r         <= an_nxt_s;
      frame_done_r <= capture_s;
    end
  end

  assign seg        = seg_r;
  assign an         = an_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_sevenseg_scan
//   Directed bench for bcd_sevenseg_scan. Instance dut_a uses REFRESH_DIV=4,
//   ACTIVE_LOW=1; instance dut_b uses REFRESH_DIV=1, ACTIVE_LOW=0. Both share
//   clock, reset and digit inputs. Expected pin values are hand-derived.
// -----------------------------------------------------------------------------
module tb_bcd_sevenseg_scan;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] units;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic [6:0] a_seg;
  logic [2:0] a_an;
  logic       a_fd;
  logic [6:0] b_seg;
  logic [2:0] b_an;
  logic       b_fd;

  int n_total = 0;
  int n_pass  = 0;

  bcd_sevenseg_scan #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .units(units), .tens(tens), .hundreds(hundreds),
    .seg(a_seg), .an(a_an), .frame_done(a_fd)
  );

  bcd_sevenseg_scan #(.REFRESH_DIV(1), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .units(units), .tens(tens), .hundreds(hundreds),
    .seg(b_seg), .an(b_an), .frame_done(b_fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 12-cycle frame of dut_a: slot expectations per 4-cycle slot,
  // frame_done only on the last cycle. Optionally changes the inputs
  // right after cycle chg_k.
  task automatic run_frame(input string tag,
                           input logic [2:0] a0, input logic [6:0] s0,
                           input logic [2:0] a1, input logic [6:0] s1,
                           input logic [2:0] a2, input logic [6:0] s2,
                           input int chg_k,
                           input logic [3:0] nh, input logic [3:0] nt, input logic [3:0] nu);
    logic [2:0] ea;
    logic [6:0] es;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k < 4) begin
        ea = a0; es = s0;
      end else if (k < 8) begin
        ea = a1; es = s1;
      end else begin
        ea = a2; es = s2;
      end
      check($sformatf("%s_an%0d", tag, k), {29'd0, a_an}, {29'd0, ea});
      check($sformatf("%s_seg%0d", tag, k), {25'd0, a_seg}, {25'd0, es});
      check($sformatf("%s_fd%0d", tag, k), {31'd0, a_fd}, {31'd0, (k == 11)});
      if (k == chg_k) begin
        hundreds = nh;
        tens     = nt;
        units    = nu;
      end
    end
  endtask

  logic [2:0] zt_a, zh_a;
  logic [6:0] zt_s, zh_s;
  logic [2:0] ban [6];
  logic [6:0] bseg[6];

  initial begin
    // Zero-snapshot frame view of tens/hundreds on dut_a (blanked or '0').
    zt_a = BL ? 3'b111 : 3'b101;
    zt_s = BL ? 7'h7F  : 7'h40;
    zh_a = BL ? 3'b111 : 3'b011;
    zh_s = BL ? 7'h7F  : 7'h40;

    rst = 1'b1; hundreds = 4'd1; tens = 4'd2; units = 4'd3;
    step(); step();
    check("rst_a_an",  {29'd0, a_an},  32'h7);
    check("rst_a_seg", {25'd0, a_seg}, 32'h7F);
    check("rst_a_fd",  {31'd0, a_fd},  32'h0);
    check("rst_b_an",  {29'd0, b_an},  32'h0);
    check("rst_b_seg", {25'd0, b_seg}, 32'h0);
    rst = 1'b0;

    // Frame 1 shows the reset snapshot; frame 2 shows 1/2/3.
    run_frame("f1", 3'b110, 7'h40, zt_a, zt_s, zh_a, zh_s, -1, 4'd0, 4'd0, 4'd0);
    // Units goes to 7 mid units-slot; the frame keeps showing 3.
    run_frame("f2", 3'b110, 7'h30, 3'b101, 7'h24, 3'b011, 7'h79, 1, 4'd1, 4'd2, 4'd7);
    // Frame 3 shows the new units; queue a non-BCD units value.
    run_frame("f3", 3'b110, 7'h78, 3'b101, 7'h24, 3'b011, 7'h79, 1, 4'd1, 4'd2, 4'hC);

    // Frame 4: dash on units, then reset while in the tens slot.
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("f4_an%0d", k),  {29'd0, a_an},  (k < 4) ? 32'h6 : 32'h5);
      check($sformatf("f4_seg%0d", k), {25'd0, a_seg}, (k < 4) ? 32'h3F : 32'h24);
    end
    rst = 1'b1;
    step();
    check("midrst_an",  {29'd0, a_an},  32'h7);
    check("midrst_seg", {25'd0, a_seg}, 32'h7F);
    check("midrst_fd",  {31'd0, a_fd},  32'h0);
    rst = 1'b0;
    run_frame("f5", 3'b110, 7'h40, zt_a, zt_s, zh_a, zh_s, -1, 4'd0, 4'd0, 4'd0);
    run_frame("f6", 3'b110, 7'h3F, 3'b101, 7'h24, 3'b011, 7'h79, -1, 4'd0, 4'd0, 4'd0);

    // Leading-zero cases: 0/0/5 then 0/4/0.
    rst = 1'b1; hundreds = 4'd0; tens = 4'd0; units = 4'd5;
    step();
    rst = 1'b0;
    run_frame("f7", 3'b110, 7'h40, zt_a, zt_s, zh_a, zh_s, -1, 4'd0, 4'd0, 4'd0);
    run_frame("f8", 3'b110, 7'h12, zt_a, zt_s, zh_a, zh_s, 0, 4'd0, 4'd4, 4'd0);
    run_frame("f9", 3'b110, 7'h40, 3'b101, 7'h19, zh_a, zh_s, -1, 4'd0, 4'd0, 4'd0);

    // dut_b: one-cycle slots, active-high pins, inputs 7/8/9.
    rst = 1'b1; hundreds = 4'd7; tens = 4'd8; units = 4'd9;
    step(); step();
    check("rst_b2_an", {29'd0, b_an}, 32'h0);
    check("rst_b2_fd", {31'd0, b_fd}, 32'h0);
    rst = 1'b0;
    ban[0] = 3'b001; bseg[0] = 7'h3F;
    ban[1] = BL ? 3'b000 : 3'b010; bseg[1] = BL ? 7'h00 : 7'h3F;
    ban[2] = BL ? 3'b000 : 3'b100; bseg[2] = BL ? 7'h00 : 7'h3F;
    ban[3] = 3'b001; bseg[3] = 7'h6F;
    ban[4] = 3'b010; bseg[4] = 7'h7F;
    ban[5] = 3'b100; bseg[5] = 7'h07;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("b_an%0d", k),  {29'd0, b_an},  {29'd0, ban[k]});
      check($sformatf("b_seg%0d", k), {25'd0, b_seg}, {25'd0, bseg[k]});
      check($sformatf("b_fd%0d", k),  {31'd0, b_fd},  {31'd0, (k == 2 || k == 5)});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
